// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_tx
//  Purpose  : Serial pattern transmitter. Latches a right-aligned bit pattern
//             of programmable length and shifts it out MSB-first on x, one
//             bit per clock, optionally repeating it. The FSM state is
//             exposed on out so detector benches can align with it.
//  Ports    : clk      - system clock, rising edge
//             reset    - asynchronous, active-low reset
//             start    - transmit request, sampled only in IDLE
//             pattern  - right-aligned pattern, pattern[len-1] sent first
//             len      - pattern length (0 = invalid, >WIDTH clamps)
//             reps     - extra repetitions (reps+1 transmissions)
//             x        - serial data bit
//             valid    - x carries a pattern bit
//             busy     - high in every state except IDLE
//             done     - one-cycle pulse after the final bit
//             out      - state code IDLE=0, SHIFT=1, GAP=2, DONE=3
//  Options  : SEQ_TX_GAP_EN - insert one GAP cycle between repetitions
//  Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       reps,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [3:0]       out
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
`ifdef SEQ_TX_GAP_EN
    localparam logic [1:0] c_GAP   = 2'd2;
`endif
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [LEN_W-1:0] c_WIDTH_LEN = LEN_W'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [WIDTH-1:0] pat_q,   pat_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [LEN_W-1:0] idx_q,   idx_d;
    logic [3:0]       reps_q,  reps_d;
    logic             x_q,     x_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [3:0]       out_q,   out_d;

    logic [LEN_W-1:0] w_len_eff;
    logic [WIDTH-1:0] w_pat_aligned;
    logic             w_last;

    // Clamp the requested length and left-align the pattern so the first bit
    // to send always sits in the MSB of the shift register.
    always_comb begin
        w_len_eff     = (len > c_WIDTH_LEN) ? c_WIDTH_LEN : len;
        w_pat_aligned = pattern << (c_WIDTH_LEN - w_len_eff);
        w_last        = (idx_q == (len_q - LEN_W'(1)));
    end

    // ------------------------------------------------------------------
    // State register (also holds datapath and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_IDLE;
            sreg_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            reps_q  <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        reps_d  = reps_q;
        case (state_q)
            c_IDLE: begin
                if (start && (len != '0)) begin
                    state_d = c_SHIFT;
                    pat_d   = w_pat_aligned;
                    sreg_d  = w_pat_aligned;
                    len_d   = w_len_eff;
                    reps_d  = reps;
                    idx_d   = '0;
                end
            end
            c_SHIFT: begin
                if (!w_last) begin
                    sreg_d = sreg_q << 1;
                    idx_d  = idx_q + LEN_W'(1);
                end else if (reps_q != 4'd0) begin
                    reps_d = reps_q - 4'd1;
`ifdef SEQ_TX_GAP_EN
                    state_d = c_GAP;
`else
                    // Back-to-back: reload so the next bit is the pattern MSB.
                    sreg_d = pat_q;
                    idx_d  = '0;
`endif
                end else begin
                    state_d = c_DONE;
                end
            end
`ifdef SEQ_TX_GAP_EN
            c_GAP: begin
                state_d = c_SHIFT;
                sreg_d  = pat_q;
                idx_d   = '0;
            end
`endif
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so outputs are registered and
    // line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        x_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = (state_d != c_IDLE);
        done_d  = (state_d == c_DONE);
        out_d   = {2'b00, state_d};
        if (state_d == c_SHIFT) begin
            x_d     = sreg_d[WIDTH-1];
            valid_d = 1'b1;
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign out   = out_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_pattern_tx
//  Purpose  : Self-checking bench for seq_pattern_tx. Expected serial bits
//             are queued when a frame is started and popped as valid bits
//             appear on x.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic        x;
    logic        valid;
    logic        busy;
    logic        done;
    logic [3:0]  out;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_q[$];

    seq_pattern_tx #(.WIDTH(16), .LEN_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .x       (x),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the bit stream a frame should produce.
    task automatic push_frame(input logic [15:0] pat, input int ln, input int rp);
        int l;
        l = (ln > 16) ? 16 : ln;
        for (int r = 0; r <= rp; r++)
            for (int i = l - 1; i >= 0; i--)
                exp_q.push_back(pat[i]);
    endtask

    // Present a start request for one edge; optionally leave start high.
    task automatic drive_start(input logic [15:0] pat, input logic [4:0] ln,
                               input logic [3:0] rp, input bit keep);
        @(negedge clk);
        pattern = pat;
        len     = ln;
        reps    = rp;
        start   = 1'b1;
        if (ln != 0) push_frame(pat, int'(ln), int'(rp));
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
    endtask

    // Consume one frame: check each valid bit, gaps and the done pulse.
    task automatic collect(input int exp_n, input int exp_gaps);
        bit seen_done;
        int gaps;
        seen_done = 1'b0;
        gaps      = 0;
        for (int n = 1; n <= 200 && !seen_done; n++) begin
            @(negedge clk);
            if (done) begin
                seen_done = 1'b1;
                chk("done_out",     out,   32'd3);
                chk("done_x",       x,     32'd0);
                chk("done_valid",   valid, 32'd0);
                chk("done_busy",    busy,  32'd1);
                chk("done_latency", n,     exp_n);
                chk("queue_empty",  exp_q.size(), 32'd0);
                chk("gap_count",    gaps,  exp_gaps);
            end else if (valid) begin
                chk("shift_out",  out,  32'd1);
                chk("shift_busy", busy, 32'd1);
                if (exp_q.size() == 0)
                    chk("bit_overflow", exp_q.size(), 32'd1);
                else
                    chk("x_bit", x, exp_q.pop_front());
            end else begin
                gaps++;
`ifdef SEQ_TX_GAP_EN
                chk("gap_out",  out,  32'd2);
                chk("gap_x",    x,    32'd0);
                chk("gap_busy", busy, 32'd1);
`else
                chk("contiguous_valid", valid, 32'd1);
`endif
            end
        end
        if (!seen_done) chk("done_timeout", seen_done, 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out"},   out,   32'd0);
        chk({tag, "_busy"},  busy,  32'd0);
        chk({tag, "_valid"}, valid, 32'd0);
        chk({tag, "_done"},  done,  32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;

        // Reset state
        #10;
        chk("rst_x", x, 32'd0);
        chk_idle("rst");
        #12;
        reset = 1'b1;

        // Single 1101 frame
        drive_start(16'h000D, 5'd4, 4'd0, 1'b0);
        collect(5, 0);
        @(negedge clk);
        chk_idle("after_f1");

        // Three repetitions of 1101
`ifdef SEQ_TX_GAP_EN
        drive_start(16'h000D, 5'd4, 4'd2, 1'b0);
        collect(15, 2);
`else
        drive_start(16'h000D, 5'd4, 4'd2, 1'b0);
        collect(13, 0);
`endif
        @(negedge clk);
        chk_idle("after_reps");

        // Length above WIDTH clamps to 16
        drive_start(16'hA5F0, 5'd20, 4'd0, 1'b0);
        collect(17, 0);

        // len=0 is ignored
        @(negedge clk);
        pattern = 16'h000D;
        len     = 5'd0;
        start   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle("len0");
        end
        start = 1'b0;

        // Mid-frame input changes ignored; held start restarts after one idle cycle
        drive_start(16'h000D, 5'd4, 4'd0, 1'b1);
        pattern = 16'h0003;
        len     = 5'd2;
        collect(5, 0);
        @(negedge clk);
        chk_idle("interframe");
        push_frame(16'h0003, 2, 0);
        collect(3, 0);
        start = 1'b0;
        @(negedge clk);
        chk_idle("held_end");
        @(negedge clk);
        chk_idle("held_end2");

        // Asynchronous reset during the third bit
        drive_start(16'h000D, 5'd4, 4'd0, 1'b0);
        @(negedge clk);
        chk("rst_b1", x, exp_q.pop_front());
        @(negedge clk);
        chk("rst_b2", x, exp_q.pop_front());
        @(negedge clk);
        chk("rst_b3", x, exp_q.pop_front());
        chk("rst_b3_valid", valid, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_x", x, 32'd0);
        chk_idle("abort");
        exp_q.delete();
        @(negedge clk);
        chk_idle("abort_hold");
        #2;
        reset = 1'b1;
        @(negedge clk);
        chk_idle("post_release");
        @(negedge clk);
        chk_idle("post_release2");
        drive_start(16'h000D, 5'd4, 4'd0, 1'b0);
        collect(5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
